// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned ENTRY_W          = 64;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side handshakes.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two instruction queue holding {instruction, pc} entries with a
// synchronous clear that takes priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = ENTRY_W,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CW'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: one outstanding memory request, a small
// instruction queue toward decode, and redirect handling that drops stale data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [CW-1:0]        count;
  logic [ENTRY_W-1:0]   head;
  logic [CW:0]          count_after;
  logic                 flush, enq, deq, issue;

  assign flush = bus.redirect_valid;
  assign deq   = bus.inst_valid && bus.inst_ready;
  assign enq   = (state_q == BUSY) && bus.imem_rvalid && !flush;

  // Issue only if the entry it will eventually produce is guaranteed a slot.
  assign count_after = {1'b0, count} + (CW+1)'(enq) - (CW+1)'(deq);
  assign issue = !reset && !flush && (count_after < (CW+1)'(DEPTH)) &&
                 ((state_q == IDLE) || ((state_q == BUSY) && bus.imem_rvalid));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;

    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY: begin
        if (flush)                 state_d = bus.imem_rvalid ? IDLE : FLUSH;
        else if (bus.imem_rvalid)  state_d = issue ? BUSY : IDLE;
      end
      FLUSH:   if (bus.imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      fetch_pc_d = align_word(bus.redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_addr_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (enq),
    .push_data_i ({bus.imem_rdata, req_addr_q}),
    .pop_i       (deq),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = head[63:32];
  assign bus.inst_pc    = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table plus hand sequences for
// backpressure, redirects, address wrap and reset with a request in flight.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vector_t;

  logic clk = 1'b0;
  logic reset;

  fetch_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          memLatency  = 1;
  logic        memPending  = 1'b0;
  int          memLeft     = 0;
  logic [31:0] memAddr     = 32'h0;
  logic        obsReq, obsValid, obsRvalid;
  logic [31:0] obsAddr, obsPc, obsData;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] wordFor(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic vector_t mkVec(input logic rst, input logic ready,
                                    input logic rv, input logic [31:0] rpc,
                                    input logic eReq, input logic [31:0] eAddr,
                                    input logic eValid, input logic [31:0] ePc);
    vector_t v;
    v.rst = rst; v.ready = ready; v.redirValid = rv; v.redirPc = rpc;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid; v.expPc = ePc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock: drive inputs and memory response, sample, then let memory see the request.
  task automatic applyStimulus(input logic rst, input logic ready,
                               input logic redirValid, input logic [31:0] redirPc);
    reset              = rst;
    bus.inst_ready     = ready;
    bus.redirect_valid = redirValid;
    bus.redirect_pc    = redirPc;
    obsRvalid          = memPending && (memLeft == 1);
    bus.imem_rvalid    = obsRvalid;
    bus.imem_rdata     = obsRvalid ? wordFor(memAddr) : $urandom;
    #1;
    obsReq   = bus.imem_req;
    obsAddr  = bus.imem_addr;
    obsValid = bus.inst_valid;
    obsPc    = bus.inst_pc;
    obsData  = bus.inst_data;
    @(posedge clk);
    if (obsRvalid) memPending = 1'b0;
    else if (memPending) memLeft--;
    if (obsReq) begin
      checkOutput("single outstanding request", 32'(memPending), 32'd0);
      memPending = 1'b1;
      memLeft    = memLatency;
      memAddr    = obsAddr;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_t vecs[$];
    int      reqs;
    int      got;
    logic    found;
    logic    sawValid;

    reset = 1'b1;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // rst ready redir redirPc | req addr | valid pc
    vecs.push_back(mkVec(1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   1, 32'h14,  1, 32'h8));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h18,  1, 32'h8));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h1C,  1, 32'hC));
    vecs.push_back(mkVec(0, 1, 1, 32'h203, 0, 32'h0,   1, 32'h10));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200));
    vecs.push_back(mkVec(0, 1, 0, 32'h0,   1, 32'h20C, 1, 32'h204));

    memLatency = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].redirValid, vecs[i].redirPc);
      checkOutput($sformatf("vec%0d imem_req", i), 32'(obsReq), 32'(vecs[i].expReq));
      if (vecs[i].expReq)
        checkOutput($sformatf("vec%0d imem_addr", i), obsAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d inst_valid", i), 32'(obsValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d inst_pc", i), obsPc, vecs[i].expPc);
        checkOutput($sformatf("vec%0d inst_data", i), obsData, wordFor(vecs[i].expPc));
      end
    end

    // Backpressure: decode stalled for 10 cycles, then drained in order.
    memLatency = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (obsReq) reqs++;
    end
    checkOutput("stall request count", 32'(reqs), 32'd4);
    checkOutput("stall inst_valid", 32'(obsValid), 32'd1);
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (obsValid) begin
        checkOutput($sformatf("drain%0d inst_pc", got), obsPc, 32'(got * 4));
        checkOutput($sformatf("drain%0d inst_data", got), obsData, wordFor(32'(got * 4)));
        got++;
      end
    end
    checkOutput("drain word count", 32'(got), 32'd4);

    // Redirect while BUSY, stale response lands three cycles later.
    memLatency = 4;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("busy-redirect first req", 32'(obsReq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1003);
    checkOutput("busy-redirect req suppressed", 32'(obsReq), 32'd0);
    found = 1'b0;
    sawValid = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (obsValid) sawValid = 1'b1;
      if (obsReq) begin
        found = 1'b1;
        checkOutput("busy-redirect refetch addr", obsAddr, 32'h1000);
      end
    end
    checkOutput("busy-redirect refetch seen", 32'(found), 32'd1);
    checkOutput("busy-redirect stale dropped", 32'(sawValid), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (obsValid) begin
        found = 1'b1;
        checkOutput("busy-redirect inst_pc", obsPc, 32'h1000);
        checkOutput("busy-redirect inst_data", obsData, wordFor(32'h1000));
      end
    end
    checkOutput("busy-redirect inst seen", 32'(found), 32'd1);

    // Two redirects back to back: the second one wins while flushing.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 8 && memPending; c++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (obsReq) begin
        found = 1'b1;
        checkOutput("double-redirect refetch addr", obsAddr, 32'h80);
      end
    end
    checkOutput("double-redirect refetch seen", 32'(found), 32'd1);

    // Fetch address wraps past the top of memory.
    memLatency = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (obsReq) begin
        found = 1'b1;
        checkOutput("wrap first addr", obsAddr, 32'hFFFF_FFFC);
      end
    end
    checkOutput("wrap first req seen", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap second req", 32'(obsReq), 32'd1);
    checkOutput("wrap second addr", obsAddr, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap inst_pc top", obsPc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap inst_pc zero", obsPc, 32'h0000_0000);

    // Reset lands with a request in flight; its late response must be ignored.
    memLatency = 3;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (obsReq && obsAddr != 32'h0) found = 1'b1;
    end
    checkOutput("midreset request in flight", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("midreset imem_req", 32'(obsReq), 32'd0);
    checkOutput("midreset inst_valid", 32'(obsValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("midreset late rvalid present", 32'(obsRvalid), 32'd1);
    checkOutput("midreset refetch req", 32'(obsReq), 32'd1);
    checkOutput("midreset refetch addr", obsAddr, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (obsValid) begin
        found = 1'b1;
        checkOutput("midreset first inst_pc", obsPc, 32'h0);
        checkOutput("midreset first inst_data", obsData, wordFor(32'h0));
      end
    end
    checkOutput("midreset inst seen", 32'(found), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
